// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. It works alongside the
//   forwarding unit and handles the cases that forwarding cannot cover:
//     - load-use hazard  : hold PC and IF/ID for one cycle, bubble into ID/EX
//     - taken branch     : flush IF/ID and ID/EX (wrong-path squash)
//     - memory busy      : freeze every stage register until MEM_Ready,
//                          with a watchdog that latches MemError on timeout
//   Outputs are Mealy: they are combinational from the state and the current
//   inputs, so a hazard is acted on in the same cycle it becomes visible.
//
// Parameters
//   ZERO_REG    register index hard-wired to zero (never a hazard source)
//   MEM_TIMEOUT maximum wait-counter value in MEM_WAIT before ERROR (>= 1)
//   CNT_W       width of the saturating stall-cycle counter
//
// Ports
//   clk            in   pipeline clock, rising edge
//   reset          in   synchronous, active-high
//   IF_ID_Ra       in   first source register of the ID instruction
//   IF_ID_Rb       in   second source register of the ID instruction
//   IF_ID_UsesRb   in   ID instruction reads Rb
//   ID_EX_MemRead  in   EX instruction is a load
//   ID_EX_Rw       in   destination register of the EX instruction
//   EX_BranchTaken in   EX branch resolved taken this cycle
//   MEM_Req        in   MEM instruction accesses data memory
//   MEM_Ready      in   data memory completes this cycle
//   PCWrite        out  PC update enable
//   IF_ID_Write    out  IF/ID register enable
//   ID_EX_Bubble   out  zero control bits loaded into ID/EX
//   IF_ID_Flush    out  clear IF/ID
//   ID_EX_Flush    out  clear ID/EX
//   Freeze         out  hold every stage register, PC included
//   MemError       out  sticky watchdog error
//   StallCount     out  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned ZERO_REG    = 31,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_Ra,
  input  logic [4:0]       IF_ID_Rb,
  input  logic             IF_ID_UsesRb,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rw,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             Freeze,
  output logic             MemError,
  output logic [CNT_W-1:0] StallCount
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [4:0]        ZR     = 5'(ZERO_REG);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_lu;         // load-use hazard visible this cycle
  logic w_normal;     // branch / load-use / default rules apply this cycle
  logic w_stall_inc;  // this cycle counts as a stalled cycle

  assign w_lu = ID_EX_MemRead && (ID_EX_Rw != ZR) &&
                ((ID_EX_Rw == IF_ID_Ra) || (IF_ID_UsesRb && (ID_EX_Rw == IF_ID_Rb)));

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    Freeze       = 1'b0;
    MemError     = 1'b0;
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait;
    w_normal     = 1'b0;
    w_stall_inc  = 1'b0;

    case (r_state)
      S_RUN: begin
        if (MEM_Req && !MEM_Ready) begin
          Freeze      = 1'b1;
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          w_state_nxt = S_MEM_WAIT;
          w_wait_nxt  = WAIT_ONE;
        end else begin
          w_normal = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (MEM_Ready) begin
          // The completion cycle is never frozen; any branch held in EX
          // during the wait is acted on here.
          w_normal    = 1'b1;
          w_state_nxt = S_RUN;
          w_wait_nxt  = '0;
        end else begin
          Freeze      = 1'b1;
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
          if (r_wait == WAIT_MAX) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_wait_nxt = r_wait + WAIT_ONE;
          end
        end
      end
      S_ERROR: begin
        Freeze      = 1'b1;
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        MemError    = 1'b1;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_wait_nxt  = '0;
      end
    endcase

    // Branch squashes the ID instruction, so a coincident load-use is moot.
    if (w_normal) begin
      if (EX_BranchTaken) begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end else if (w_lu) begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end
    end

    w_stall_inc = Freeze || ID_EX_Bubble;

    if (reset) begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Bubble = 1'b0;
      IF_ID_Flush  = 1'b0;
      ID_EX_Flush  = 1'b0;
      Freeze       = 1'b0;
      MemError     = 1'b0;
      w_stall_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_wait      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_stall_inc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Two instances share one stimulus stream:
//     u_a : MEM_TIMEOUT=4,  CNT_W=16 (watchdog behaviour)
//     u_b : MEM_TIMEOUT=64, CNT_W=4  (counter saturation)
//   A behavioural model tracks, per instance, whether memory is being waited
//   on, how many cycles have been waited, whether the watchdog fired and how
//   many stall cycles have been seen, and predicts all outputs every cycle.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] ra, rb, rw;
  logic       uses_rb, mem_read, br_taken, mem_req, mem_rdy;

  logic       a_pcw, a_ifw, a_bub, a_iff, a_idf, a_frz, a_err;
  logic       b_pcw, b_ifw, b_bub, b_iff, b_idf, b_frz, b_err;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  pipeline_hazard_ctrl #(.ZERO_REG(31), .MEM_TIMEOUT(4), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset),
    .IF_ID_Ra(ra), .IF_ID_Rb(rb), .IF_ID_UsesRb(uses_rb),
    .ID_EX_MemRead(mem_read), .ID_EX_Rw(rw), .EX_BranchTaken(br_taken),
    .MEM_Req(mem_req), .MEM_Ready(mem_rdy),
    .PCWrite(a_pcw), .IF_ID_Write(a_ifw), .ID_EX_Bubble(a_bub),
    .IF_ID_Flush(a_iff), .ID_EX_Flush(a_idf), .Freeze(a_frz),
    .MemError(a_err), .StallCount(a_cnt)
  );

  pipeline_hazard_ctrl #(.ZERO_REG(31), .MEM_TIMEOUT(64), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset),
    .IF_ID_Ra(ra), .IF_ID_Rb(rb), .IF_ID_UsesRb(uses_rb),
    .ID_EX_MemRead(mem_read), .ID_EX_Rw(rw), .EX_BranchTaken(br_taken),
    .MEM_Req(mem_req), .MEM_Ready(mem_rdy),
    .PCWrite(b_pcw), .IF_ID_Write(b_ifw), .ID_EX_Bubble(b_bub),
    .IF_ID_Flush(b_iff), .ID_EX_Flush(b_idf), .Freeze(b_frz),
    .MemError(b_err), .StallCount(b_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model state, index 0 = u_a, 1 = u_b
  int  TIMEOUT [2] = '{4, 64};
  int  CNT_MAX [2] = '{65535, 15};
  bit  m_waiting [2];
  int  m_waited  [2];
  bit  m_err     [2];
  int  m_stalls  [2];

  // Applies one cycle of inputs (already at posedge+1), checks at the
  // falling edge, advances the model, returns at the next posedge+1.
  task automatic cyc(input bit rst, input int a, input int b, input bit urb,
                     input bit mrd, input int w, input bit br,
                     input bit req, input bit rdy);
    bit lu, frz, err, norm, bub, fl, pcw;
    logic [6:0] obs [2];
    logic [31:0] cnt_obs [2];
    reset = rst; ra = 5'(a); rb = 5'(b); uses_rb = urb;
    mem_read = mrd; rw = 5'(w); br_taken = br; mem_req = req; mem_rdy = rdy;
    @(negedge clk);
    obs[0] = {a_pcw, a_ifw, a_bub, a_iff, a_idf, a_frz, a_err};
    obs[1] = {b_pcw, b_ifw, b_bub, b_iff, b_idf, b_frz, b_err};
    cnt_obs[0] = 32'(a_cnt);
    cnt_obs[1] = 32'(b_cnt);
    lu = mrd && (w != 31) && ((w == a) || (urb && (w == b)));
    for (int i = 0; i < 2; i++) begin
      frz = 0; err = 0; norm = 0;
      if (rst) ;
      else if (m_err[i]) begin frz = 1; err = 1; end
      else if (m_waiting[i] ? !rdy : (req && !rdy)) frz = 1;
      else norm = 1;
      bub = norm && !br && lu;
      fl  = norm && br;
      pcw = !frz && !bub;
      check(i == 0 ? "outs_a" : "outs_b", 32'(obs[i]),
            32'({pcw, pcw, bub, fl, fl, frz, err}));
      check(i == 0 ? "cnt_a" : "cnt_b", cnt_obs[i], 32'(m_stalls[i]));
      if (rst) begin
        m_waiting[i] = 0; m_waited[i] = 0; m_err[i] = 0; m_stalls[i] = 0;
      end else begin
        if ((frz || bub) && m_stalls[i] < CNT_MAX[i]) m_stalls[i]++;
        if (!m_err[i]) begin
          if (!m_waiting[i]) begin
            if (req && !rdy) begin m_waiting[i] = 1; m_waited[i] = 1; end
          end else if (rdy) m_waiting[i] = 0;
          else if (m_waited[i] >= TIMEOUT[i]) begin m_err[i] = 1; m_waiting[i] = 0; end
          else m_waited[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rst);
    cyc(rst, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int r;
  initial begin
    reset = 1; ra = '0; rb = '0; rw = '0; uses_rb = 0; mem_read = 0;
    br_taken = 0; mem_req = 0; mem_rdy = 0;
    @(posedge clk); #1;
    // reset with hazards present: outputs forced
    cyc(1, 5, 5, 1, 1, 5, 1, 1, 0);
    idle(1);
    // load-use via Ra
    cyc(0, 5, 0, 0, 1, 5, 0, 0, 0);
    idle(0);
    check("lu_cnt", 32'(a_cnt), 32'd1);
    // Rw = zero reg: no stall; Rb match without UsesRb: no stall; with UsesRb: stall
    cyc(0, 31, 0, 0, 1, 31, 0, 0, 0);
    cyc(0, 1, 5, 0, 1, 5, 0, 0, 0);
    cyc(0, 1, 5, 1, 1, 5, 0, 0, 0);
    // back-to-back dependent loads
    cyc(0, 7, 0, 0, 1, 7, 0, 0, 0);
    cyc(0, 8, 0, 0, 1, 8, 0, 0, 0);
    // branch + load-use: flush wins, no count
    cyc(0, 5, 0, 0, 1, 5, 1, 0, 0);
    // memory wait 3 cycles, branch held during wait
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(0);
    check("memwait_cnt", 32'(a_cnt), 32'd3);
    // watchdog: ready held low, then inputs toggle
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("wd_err", 32'(a_err), 32'd1);
    for (int k = 0; k < 6; k++)
      cyc(0, k, k, k[0], k[1], k, k[0], k[1], k[2]);
    // saturation on u_b
    idle(1);
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("sat_b", 32'(b_cnt), 32'd15);
    // reset in second cycle of the wait
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      cyc(r < 2,
          $urandom_range(4, 7), $urandom_range(4, 7), 1'($urandom),
          $urandom_range(0, 2) != 0,
          ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(4, 7),
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) < 4);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Stall/flush sequencer for the 5-stage pipeline, working alongside the forwarding unit.
- Detects load-use hazards that forwarding cannot cover and inserts a bubble.
- Squashes wrong-path instructions on a taken branch.
- Freezes the whole pipeline while data memory is busy, with a watchdog that latches an error when memory never responds.
- Drives PC / IF_ID write enables, flush and bubble controls, and keeps a stall-cycle counter.

## Interface
- ZERO_REG, 31: register index hard-wired to zero; never a hazard source.
- MEM_TIMEOUT, 64: maximum wait cycles in MEM_WAIT before error (≥1).
- CNT_W, 16: stall counter width.

- clk  in  1  pipeline clock; everything sampled on rising edge.
- reset  in  1  synchronous, active-high.
- IF_ID_Ra  in  5  first source register of the instruction in ID.
- IF_ID_Rb  in  5  second source register of the instruction in ID.
- IF_ID_UsesRb  in  1  instruction in ID reads Rb.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_Rw  in  5  destination of the instruction in EX.
- EX_BranchTaken  in  1  branch in EX resolved taken this cycle.
- MEM_Req  in  1  instruction in MEM accesses data memory.
- MEM_Ready  in  1  data memory completes this cycle.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Bubble  out  1  zero all control bits loaded into ID/EX.
- IF_ID_Flush  out  1  clear IF/ID.
- ID_EX_Flush  out  1  clear ID/EX.
- Freeze  out  1  hold every stage register, PC included.
- MemError  out  1  sticky watchdog error.
- StallCount  out  CNT_W  saturating count of stalled cycles.

## Operation
- FSM states:
  - RUN.
  - MEM_WAIT.
  - ERROR.
- Registers:
  - state.
  - wait counter (≥ clog2(MEM_TIMEOUT+1) bits).
  - StallCount.
- Outputs are combinational from state and current inputs (Mealy), so a stall takes effect in the same cycle the hazard is visible.

- Load-use hazard (LU) is true when all of the following hold:
  - ID_EX_MemRead = 1.
  - ID_EX_Rw ≠ ZERO_REG.
  - Either ID_EX_Rw == IF_ID_Ra, or (IF_ID_UsesRb and ID_EX_Rw == IF_ID_Rb).

- RUN, output priority:
  1. MEM_Req & !MEM_Ready:
     - Freeze=1, PCWrite=0, IF_ID_Write=0.
     - Flushes and bubble are 0.
     - Next state MEM_WAIT; wait counter ← 1.
  2. Else EX_BranchTaken:
     - IF_ID_Flush=1, ID_EX_Flush=1.
     - LU is ignored, because the ID instruction is squashed.
     - PCWrite=1, IF_ID_Write=1.
  3. Else LU:
     - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
  4. Else all enables are 1 and all flush/bubble/freeze outputs are 0.

- MEM_WAIT:
  - MEM_Ready=1:
    - Freeze=0 this cycle.
    - Branch, LU and default rules apply exactly as in RUN.
    - Next state RUN; wait counter ← 0.
  - MEM_Ready=0 and wait counter < MEM_TIMEOUT:
    - Freeze=1, PCWrite=0, IF_ID_Write=0.
    - Wait counter increments.
  - MEM_Ready=0 and wait counter == MEM_TIMEOUT:
    - Freeze=1.
    - Next state ERROR.
- ERROR:
  - Freeze=1, PCWrite=0, IF_ID_Write=0.
  - MemError=1; all inputs ignored until reset.
- MemError = (state == ERROR).
- StallCount:
  - +1 on every cycle where Freeze=1, or where LU stalls in cycles with Freeze=0.
  - Flush-only cycles do not count.
  - Saturates at 2^CNT_W−1.
- One LU stall lasts exactly one cycle. On the next cycle ID/EX holds the bubble (MemRead=0) and the forwarding unit supplies the load result.
- Back-to-back loads each produce their own one-cycle stall when dependent.

## Timing
- Reset (sync, active-high), next edge:
  - state=RUN, wait counter=0, StallCount=0, MemError=0.
  - While reset is high, outputs are forced to PCWrite=1, IF_ID_Write=1, all other 1-bit outputs 0.
- Response latency to LU, branch and memory-busy: 0 cycles (same cycle).
- Memory handshake: one memory access takes (cycles until MEM_Ready) + 1; the cycle where MEM_Ready=1 is never frozen.
- Timeout: if MEM_Ready stays low, Freeze is high for the MEM_TIMEOUT+1 cycles up to the ERROR transition. The ERROR state is entered at the edge following the cycle where wait counter == MEM_TIMEOUT, and MemError=1 from then on.
- Reset in MEM_WAIT or ERROR returns to RUN at the next edge; pending counts are discarded.
- Simultaneous events:
  - Branch + LU: flush wins.
  - Memory busy + branch: freeze wins; the branch is still held in EX and is acted on in the MEM_Ready cycle.
- StallCount at saturation stays constant; it never wraps.

## Test plan
- Load-use stall:
  - Stimulus: ID_EX_MemRead=1, ID_EX_Rw=5, IF_ID_Ra=5.
  - Response: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for one cycle; StallCount 0→1.
  - Repeat with Rw=31, and separately with IF_ID_Rb=5 and UsesRb=0: no stall.
- Branch flush:
  - Stimulus: EX_BranchTaken=1 together with an LU condition.
  - Response: IF_ID_Flush=ID_EX_Flush=1, ID_EX_Bubble=0, PCWrite=1; StallCount unchanged.
- Memory wait:
  - Stimulus: MEM_Req=1, MEM_Ready low for 3 cycles, then high.
  - Response: Freeze=1 for exactly 3 cycles, 0 in the ready cycle; state back to RUN; StallCount=3.
- Watchdog:
  - Stimulus: MEM_TIMEOUT=4, MEM_Req=1, MEM_Ready held 0.
  - Response: Freeze high 5 cycles, then MemError=1 persists while inputs toggle.
  - Reset clears to RUN with MemError=0 and StallCount=0.
- Saturation:
  - Stimulus: CNT_W=4, 20 consecutive frozen cycles (MEM_TIMEOUT large).
  - Response: StallCount stops at 15.
- Reset mid-wait:
  - Stimulus: assert reset in cycle 2 of MEM_WAIT.
  - Response: next cycle state=RUN, Freeze=0, counters 0.
